// File: rtl/pixel_sliding_window.sv
// pixel_sliding_window
//   Builds a BUFFER_SIZE x BUFFER_SIZE neighbourhood from a raster pixel stream.
//   It accepts one pixel on every rising clock edge while reset is released.
//   BUFFER_SIZE-1 circular line buffers, each ROW_SIZE pixels deep, are
//   cascaded so that row r lags the input by (BUFFER_SIZE-1-r) image rows.
//   Each row then feeds a BUFFER_SIZE-deep horizontal shift register, and the
//   taps of that register form window[r][*].
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset; clears the window and the line buffers
//   inputPixel : next raster pixel, sampled on every edge while rst is high
//   window     : registered window, window[r][c]; r=0 is the oldest row and
//                c=0 is the oldest column
module pixel_sliding_window #(
    parameter int WORD_SIZE   = 8,
    parameter int BUFFER_SIZE = 3,
    parameter int ROW_SIZE    = 540
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [WORD_SIZE-1:0]                             inputPixel,
    output logic [BUFFER_SIZE-1:0][BUFFER_SIZE-1:0][WORD_SIZE-1:0] window
);

    localparam int NUM_LB = BUFFER_SIZE - 1;
    localparam int PTR_W  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ROW_SIZE - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WORD_SIZE-1:0] lb_q [NUM_LB][ROW_SIZE];
    logic [WORD_SIZE-1:0] lb_d [NUM_LB][ROW_SIZE];
    logic [BUFFER_SIZE-1:0][BUFFER_SIZE-1:0][WORD_SIZE-1:0] win_q, win_d;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] row_in;

    always_comb begin
        // The newest row takes the live pixel. Line buffer l is read before it
        // is written at the shared pointer, so it returns the sample written
        // ROW_SIZE edges earlier, which is the pixel for row BUFFER_SIZE-2-l.
        row_in = '0;
        row_in[BUFFER_SIZE-1] = inputPixel;
        for (int l = 0; l < NUM_LB; l++) begin
            row_in[BUFFER_SIZE-2-l] = lb_q[l][ptr_q];
        end

        // Buffer 0 stores the live pixel. Each later buffer stores the output
        // of the buffer before it, which builds the cascade of row delays.
        lb_d = lb_q;
        for (int l = 0; l < NUM_LB; l++) begin
            if (l == 0) begin
                lb_d[l][ptr_q] = inputPixel;
            end else begin
                lb_d[l][ptr_q] = lb_q[l-1][ptr_q];
            end
        end

        // Each row shifts toward column 0; the new sample enters the newest column.
        win_d = win_q;
        for (int r = 0; r < BUFFER_SIZE; r++) begin
            for (int c = 0; c < BUFFER_SIZE - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][BUFFER_SIZE-1] = row_in[r];
        end

        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            win_q <= '0;
            for (int l = 0; l < NUM_LB; l++) begin
                for (int a = 0; a < ROW_SIZE; a++) begin
                    lb_q[l][a] <= '0;
                end
            end
        end else begin
            ptr_q <= ptr_d;
            win_q <= win_d;
            lb_q  <= lb_d;
        end
    end

    assign window = win_q;

endmodule

// File: tb/tb_pixel_sliding_window.sv
// Testbench for pixel_sliding_window.
// The small instance uses ROW_SIZE=4. The second instance keeps the default
// parameters (ROW_SIZE=540).
module tb_pixel_sliding_window;

    typedef logic [2:0][7:0]       row_t;
    typedef logic [2:0][2:0][7:0]  win_t;

    typedef struct {
        int   due;
        bit   big;
        int   tag;
        win_t exp;
    } ent_t;

    logic       clk;
    logic       rst_s, rst_b;
    logic [7:0] pix_s, pix_b;
    win_t       win_s, win_b;

    int   cyc;
    int   total;
    int   bad;
    int   tag_n;
    bit   flush;
    ent_t sbq[$];
    ent_t ent;
    win_t act;

    pixel_sliding_window #(.WORD_SIZE(8), .BUFFER_SIZE(3), .ROW_SIZE(4)) dut (
        .clk(clk), .rst(rst_s), .inputPixel(pix_s), .window(win_s)
    );

    pixel_sliding_window dut_big (
        .clk(clk), .rst(rst_b), .inputPixel(pix_b), .window(win_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t rw(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        row_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return v;
    endfunction

    function automatic win_t mk(input row_t r0, input row_t r1, input row_t r2);
        win_t w;
        w[0] = r0;
        w[1] = r1;
        w[2] = r2;
        return w;
    endfunction

    // Expected value for the window that is due at cycle index cyc+lag.
    task automatic expect_win(input win_t e, input int lag, input bit big);
        tag_n = tag_n + 1;
        sbq.push_back('{due: cyc + lag, big: big, tag: tag_n, exp: e});
    endtask

    task automatic drive(input logic [7:0] p);
        @(negedge clk);
        pix_s = p;
    endtask

    task automatic start(input logic [7:0] p);
        @(negedge clk);
        rst_s = 1'b1;
        pix_s = p;
    endtask

    // Monitor: compares at the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            ent = sbq.pop_front();
            act = ent.big ? win_b : win_s;
            total = total + 1;
            if (ent.due != cyc || act !== ent.exp) begin
                bad = bad + 1;
                $display("FAIL win_chk%0d cyc=%0d due=%0d got=%h want=%h",
                         ent.tag, cyc, ent.due, act, ent.exp);
            end
        end
        if (flush) begin
            while (sbq.size() > 0) begin
                ent = sbq.pop_front();
                total = total + 1;
                bad = bad + 1;
                $display("FAIL win_chk%0d never sampled got=%h want=%h", ent.tag, act, ent.exp);
            end
        end
    end

    initial begin
        win_t z;
        z     = '0;
        cyc   = 0;
        total = 0;
        bad   = 0;
        tag_n = 0;
        flush = 1'b0;
        rst_s = 1'b0;
        rst_b = 1'b0;
        pix_s = 8'h00;
        pix_b = 8'h00;

        // Reset held: toggling input must be ignored.
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 8'hFF : 8'h00);
            expect_win(z, 1, 1'b0);
        end

        // Fill, then an asynchronous drop between edges.
        start(8'd1);
        drive(8'd2);
        drive(8'd3);
        expect_win(mk('0, '0, rw(8'd1, 8'd2, 8'd3)), 1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        expect_win(z, 0, 1'b0);

        // Run A: P(k)=k for k=1..21.
        start(8'd1);
        for (int k = 2; k <= 21; k++) begin
            drive(8'(k));
            case (k)
                3:  expect_win(mk('0, '0, rw(8'd1, 8'd2, 8'd3)), 1, 1'b0);
                5:  expect_win(mk('0, rw(8'd0, 8'd0, 8'd1), rw(8'd3, 8'd4, 8'd5)), 1, 1'b0);
                9:  expect_win(mk(rw(8'd0, 8'd0, 8'd1), rw(8'd3, 8'd4, 8'd5), rw(8'd7, 8'd8, 8'd9)), 1, 1'b0);
                20: expect_win(mk(rw(8'd10, 8'd11, 8'd12), rw(8'd14, 8'd15, 8'd16), rw(8'd18, 8'd19, 8'd20)), 1, 1'b0);
                21: expect_win(mk(rw(8'd11, 8'd12, 8'd13), rw(8'd15, 8'd16, 8'd17), rw(8'd19, 8'd20, 8'd21)), 1, 1'b0);
                default: ;
            endcase
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        expect_win(z, 0, 1'b0);

        // Run B: 15 pixels, a reset pulse, then 0x80, 0x81 (line buffers must be clear).
        start(8'd1);
        for (int k = 2; k <= 15; k++) begin
            drive(8'(k));
        end
        expect_win(mk(rw(8'd5, 8'd6, 8'd7), rw(8'd9, 8'd10, 8'd11), rw(8'd13, 8'd14, 8'd15)), 1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        expect_win(z, 0, 1'b0);
        start(8'h80);
        drive(8'h81);
        expect_win(mk('0, '0, rw(8'h00, 8'h80, 8'h81)), 1, 1'b0);

        // Default-parameter instance: k mod 256 for 1100 pixels.
        @(negedge clk);
        rst_b = 1'b1;
        pix_b = 8'd1;
        for (int k = 2; k <= 1100; k++) begin
            @(negedge clk);
            pix_b = 8'(k);
            if (k == 542)
                expect_win(mk('0, rw(8'd0, 8'd1, 8'd2), rw(8'd28, 8'd29, 8'd30)), 1, 1'b1);
            if (k == 1100)
                expect_win(mk(rw(8'd18, 8'd19, 8'd20), rw(8'd46, 8'd47, 8'd48), rw(8'd74, 8'd75, 8'd76)), 1, 1'b1);
        end

        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
